// File: rtl/mips_pipe_pkg.sv
// mips_pipe_pkg: shared forwarding encodings, memory-wait FSM states and register-compare helper
package mips_pipe_pkg;
  localparam logic [1:0] FWD_REGFILE = 2'b00;
  localparam logic [1:0] FWD_RESULTW = 2'b01;
  localparam logic [1:0] FWD_ALUOUTM = 2'b10;
  localparam logic [4:0] REG_ZERO = 5'd0;
  typedef enum logic [1:0] {RUN = 2'd0, MEM_WAIT = 2'd1, ERR = 2'd2} mem_state_e;
  // $0 is hardwired, so it never creates a dependency
  function automatic logic reg_match(input logic [4:0] a, input logic [4:0] b);
    return (a != REG_ZERO) && (a == b);
  endfunction
endpackage

// File: rtl/mem_wait_fsm.sv
// mem_wait_fsm: tracks an outstanding multi-cycle M-stage access with timeout watchdog
module mem_wait_fsm
  import mips_pipe_pkg::*;
#(
  parameter int TIMEOUT = 255,
  parameter int CNT_W = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic MemReqM,
  input  logic MemAckM,
  output logic memstall,
  output logic MemErr
);
  mem_state_e state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RUN;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
    end
  end
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    memstall = 1'b0;
    case (state_q)
      RUN: begin
        cnt_d = '0;
        memstall = MemReqM & ~MemAckM;
        state_d = (MemReqM & ~MemAckM) ? MEM_WAIT : RUN;
      end
      MEM_WAIT: begin
        memstall = ~MemAckM;
        cnt_d = MemAckM ? '0 : cnt_q + 1'b1;
        state_d = MemAckM ? RUN : (cnt_q == CNT_W'(TIMEOUT - 1)) ? ERR : MEM_WAIT;
      end
      ERR: memstall = 1'b1;
      default: state_d = RUN;
    endcase
  end
  assign MemErr = (state_q == ERR);
endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: stall/flush/bubble and forwarding control for the 5-stage MIPS pipeline
// Optional PERF_CNT_EN adds StallCnt/FlushCnt performance counters.
module pipeline_hazard_ctrl
  import mips_pipe_pkg::*;
#(
  parameter int TIMEOUT = 255,
  parameter int CNT_W = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] RsD,
  input  logic [4:0] RtD,
  input  logic [4:0] RsE,
  input  logic [4:0] RtE,
  input  logic [4:0] WriteRegE,
  input  logic [4:0] WriteRegM,
  input  logic [4:0] WriteRegW,
  input  logic       RegWriteE,
  input  logic       RegWriteM,
  input  logic       RegWriteW,
  input  logic       MemtoRegE,
  input  logic       MemtoRegM,
  input  logic       BranchD,
  input  logic       MemReqM,
  input  logic       MemAckM,
  output logic       StallF,
  output logic       StallD,
  output logic       StallE,
  output logic       StallM,
  output logic       FlushE,
  output logic       BubbleW,
  output logic [1:0] ForwardAE,
  output logic [1:0] ForwardBE,
  output logic       ForwardAD,
  output logic       ForwardBD,
`ifdef PERF_CNT_EN
  output logic [31:0] StallCnt,
  output logic [31:0] FlushCnt,
`endif
  output logic       MemErr
);
  logic memstall_raw, memstall, lwstall, brstall;
  mem_wait_fsm #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) u_fsm (
    .clk(clk), .rst(rst), .MemReqM(MemReqM), .MemAckM(MemAckM),
    .memstall(memstall_raw), .MemErr(MemErr)
  );
  // Stage enables are forced inactive while reset is asserted
  always_comb begin
    lwstall = MemtoRegE & (reg_match(RsD, RtE) | reg_match(RtD, RtE));
    brstall = BranchD & ((RegWriteE & (reg_match(RsD, WriteRegE) | reg_match(RtD, WriteRegE)))
                       | (MemtoRegM & (reg_match(RsD, WriteRegM) | reg_match(RtD, WriteRegM))));
    memstall = ~rst & memstall_raw;
    StallF = ~rst & (memstall | lwstall | brstall);
    StallD = StallF;
    StallE = memstall;
    StallM = memstall;
    BubbleW = memstall;
    FlushE = ~rst & (lwstall | brstall) & ~memstall;
    ForwardAE = (RegWriteM & reg_match(RsE, WriteRegM)) ? FWD_ALUOUTM :
                (RegWriteW & reg_match(RsE, WriteRegW)) ? FWD_RESULTW : FWD_REGFILE;
    ForwardBE = (RegWriteM & reg_match(RtE, WriteRegM)) ? FWD_ALUOUTM :
                (RegWriteW & reg_match(RtE, WriteRegW)) ? FWD_RESULTW : FWD_REGFILE;
    ForwardAD = RegWriteM & reg_match(RsD, WriteRegM);
    ForwardBD = RegWriteM & reg_match(RtD, WriteRegM);
  end
`ifdef PERF_CNT_EN
  logic [31:0] stall_cnt_q, flush_cnt_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_q + {31'd0, StallF};
      flush_cnt_q <= flush_cnt_q + {31'd0, FlushE};
    end
  end
  assign StallCnt = stall_cnt_q;
  assign FlushCnt = flush_cnt_q;
`endif
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl: directed self-checking bench for pipeline_hazard_ctrl (TIMEOUT=4)
module tb_pipeline_hazard_ctrl;
  logic clk = 1'b0, rst = 1'b1;
  logic [4:0] RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW;
  logic RegWriteE, RegWriteM, RegWriteW, MemtoRegE, MemtoRegM, BranchD, MemReqM, MemAckM;
  logic StallF, StallD, StallE, StallM, FlushE, BubbleW, ForwardAD, ForwardBD, MemErr;
  logic [1:0] ForwardAE, ForwardBE;
`ifdef PERF_CNT_EN
  logic [31:0] StallCnt, FlushCnt;
`endif
  int checks = 0, failures = 0;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.TIMEOUT(4), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .RsD(RsD), .RtD(RtD), .RsE(RsE), .RtE(RtE),
    .WriteRegE(WriteRegE), .WriteRegM(WriteRegM), .WriteRegW(WriteRegW),
    .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .MemtoRegE(MemtoRegE), .MemtoRegM(MemtoRegM), .BranchD(BranchD),
    .MemReqM(MemReqM), .MemAckM(MemAckM),
    .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
    .FlushE(FlushE), .BubbleW(BubbleW), .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .ForwardAD(ForwardAD), .ForwardBD(ForwardBD),
`ifdef PERF_CNT_EN
    .StallCnt(StallCnt), .FlushCnt(FlushCnt),
`endif
    .MemErr(MemErr)
  );

  task automatic clear_inputs();
    {RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW} = '0;
    {RegWriteE, RegWriteM, RegWriteW, MemtoRegE, MemtoRegM, BranchD, MemReqM, MemAckM} = '0;
  endtask

  // outs = {StallF,StallD,StallE,StallM,FlushE,BubbleW}
  task automatic test_reset();
    clear_inputs();
    MemReqM = 1'b1; MemtoRegE = 1'b1; RtE = 5'd5; RsD = 5'd5;
    @(negedge clk); #1;
    checks++;
    if ({StallF, StallD, StallE, StallM, FlushE, BubbleW} !== 6'b0) begin
      failures++; $display("FAIL reset_outs got=%b exp=000000", {StallF, StallD, StallE, StallM, FlushE, BubbleW});
    end
    checks++;
    if (MemErr !== 1'b0) begin failures++; $display("FAIL reset_memerr got=%b exp=0", MemErr); end
    clear_inputs();
    @(negedge clk); rst = 1'b0; #1;
    checks++;
    if ({StallF, StallE, FlushE, BubbleW, MemErr} !== 5'b0) begin
      failures++; $display("FAIL idle_outs got=%b exp=00000", {StallF, StallE, FlushE, BubbleW, MemErr});
    end
  endtask

  task automatic test_forward();
    clear_inputs();
    @(negedge clk);
    RsE = 5'd3; RegWriteM = 1'b1; WriteRegM = 5'd3; RegWriteW = 1'b1; WriteRegW = 5'd3; #1;
    checks++;
    if (ForwardAE !== 2'b10) begin failures++; $display("FAIL fwd_ae_m got=%b exp=10", ForwardAE); end
    WriteRegM = 5'd4; #1;
    checks++;
    if (ForwardAE !== 2'b01) begin failures++; $display("FAIL fwd_ae_w got=%b exp=01", ForwardAE); end
    RtE = 5'd4; #1;
    checks++;
    if (ForwardBE !== 2'b10) begin failures++; $display("FAIL fwd_be_m got=%b exp=10", ForwardBE); end
    RegWriteW = 1'b0; #1;
    checks++;
    if (ForwardAE !== 2'b00) begin failures++; $display("FAIL fwd_ae_none got=%b exp=00", ForwardAE); end
    RsE = 5'd0; RegWriteW = 1'b1; WriteRegW = 5'd0; RegWriteM = 1'b1; WriteRegM = 5'd0; #1;
    checks++;
    if (ForwardAE !== 2'b00) begin failures++; $display("FAIL fwd_ae_zero got=%b exp=00", ForwardAE); end
    RsD = 5'd9; WriteRegM = 5'd9; #1;
    checks++;
    if ({ForwardAD, ForwardBD} !== 2'b10) begin failures++; $display("FAIL fwd_ad got=%b exp=10", {ForwardAD, ForwardBD}); end
  endtask

  task automatic test_lwstall();
    clear_inputs();
    @(negedge clk);
    MemtoRegE = 1'b1; RtE = 5'd5; RsD = 5'd5; #1;
    checks++;
    if ({StallF, StallD, FlushE, StallE, StallM, BubbleW} !== 6'b111000) begin
      failures++; $display("FAIL lwstall got=%b exp=111000", {StallF, StallD, FlushE, StallE, StallM, BubbleW});
    end
    RsD = 5'd1; RtD = 5'd5; #1;
    checks++;
    if ({StallF, FlushE} !== 2'b11) begin failures++; $display("FAIL lwstall_rt got=%b exp=11", {StallF, FlushE}); end
    RtE = 5'd0; RsD = 5'd0; RtD = 5'd0; #1;
    checks++;
    if ({StallF, FlushE} !== 2'b00) begin failures++; $display("FAIL lwstall_zero got=%b exp=00", {StallF, FlushE}); end
  endtask

  task automatic test_branch();
    clear_inputs();
    @(negedge clk);
    BranchD = 1'b1; RegWriteE = 1'b1; WriteRegE = 5'd7; RtD = 5'd7; #1;
    checks++;
    if ({StallD, FlushE, StallE} !== 3'b110) begin failures++; $display("FAIL brstall_e got=%b exp=110", {StallD, FlushE, StallE}); end
    WriteRegM = 5'd7; RegWriteM = 1'b1; #1;
    checks++;
    if (ForwardBD !== 1'b1) begin failures++; $display("FAIL fwd_bd got=%b exp=1", ForwardBD); end
    RegWriteE = 1'b0; #1;
    checks++;
    if (StallD !== 1'b0) begin failures++; $display("FAIL br_alu_m_nostall got=%b exp=0", StallD); end
    MemtoRegM = 1'b1; #1;
    checks++;
    if ({StallD, FlushE} !== 2'b11) begin failures++; $display("FAIL brstall_m got=%b exp=11", {StallD, FlushE}); end
  endtask

  task automatic test_mem_wait();
    clear_inputs();
    @(negedge clk);
    MemReqM = 1'b1; MemAckM = 1'b1; #1;
    checks++;
    if ({StallF, StallE, BubbleW} !== 3'b000) begin failures++; $display("FAIL ack_same_cycle got=%b exp=000", {StallF, StallE, BubbleW}); end
    @(negedge clk);
    MemAckM = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      checks++;
      if ({StallF, StallD, StallE, StallM, BubbleW, FlushE} !== 6'b111110) begin
        failures++; $display("FAIL memwait_cyc%0d got=%b exp=111110", i, {StallF, StallD, StallE, StallM, BubbleW, FlushE});
      end
    end
    @(negedge clk);
    MemAckM = 1'b1; #1;
    checks++;
    if ({StallF, StallE, StallM, BubbleW} !== 4'b0000) begin failures++; $display("FAIL memwait_ack got=%b exp=0000", {StallF, StallE, StallM, BubbleW}); end
    @(negedge clk);
    MemReqM = 1'b0; MemAckM = 1'b0; #1;
    checks++;
    if ({StallF, StallE, MemErr} !== 3'b000) begin failures++; $display("FAIL memwait_run got=%b exp=000", {StallF, StallE, MemErr}); end
  endtask

  task automatic test_timeout();
    clear_inputs();
    @(negedge clk);
    MemReqM = 1'b1;
    for (int i = 0; i < 4; i++) @(negedge clk);
    #1;
    checks++;
    if ({MemErr, StallE} !== 2'b01) begin failures++; $display("FAIL timeout_early got=%b exp=01", {MemErr, StallE}); end
    @(negedge clk); #1;
    checks++;
    if ({MemErr, StallF, StallE, BubbleW} !== 4'b1111) begin failures++; $display("FAIL timeout_err got=%b exp=1111", {MemErr, StallF, StallE, BubbleW}); end
    @(negedge clk);
    MemReqM = 1'b0; MemAckM = 1'b1; #1;
    checks++;
    if ({MemErr, StallE} !== 2'b11) begin failures++; $display("FAIL err_sticky got=%b exp=11", {MemErr, StallE}); end
    MemAckM = 1'b0; MemtoRegE = 1'b1; RtE = 5'd5; RsD = 5'd5; #1;
    checks++;
    if ({FlushE, StallE, StallF} !== 3'b011) begin failures++; $display("FAIL lw_during_mem got=%b exp=011", {FlushE, StallE, StallF}); end
    @(negedge clk);
    rst = 1'b1; #1;
    checks++;
    if ({StallF, StallD, StallE, StallM, FlushE, BubbleW, MemErr} !== 7'b0) begin
      failures++; $display("FAIL rst_pulse got=%b exp=0000000", {StallF, StallD, StallE, StallM, FlushE, BubbleW, MemErr});
    end
    clear_inputs();
    @(negedge clk);
    rst = 1'b0; #1;
    checks++;
    if ({StallF, StallE, MemErr} !== 3'b000) begin failures++; $display("FAIL post_rst got=%b exp=000", {StallF, StallE, MemErr}); end
  endtask

`ifdef PERF_CNT_EN
  task automatic test_perf();
    checks++;
    if ({StallCnt, FlushCnt} !== 64'd0) begin failures++; $display("FAIL perf_zero got=%0d/%0d exp=0/0", StallCnt, FlushCnt); end
    @(negedge clk);
    MemtoRegE = 1'b1; RtE = 5'd5; RsD = 5'd5;
    repeat (3) @(negedge clk);
    clear_inputs();
    MemReqM = 1'b1;
    repeat (2) @(negedge clk);
    MemAckM = 1'b1;
    @(negedge clk);
    clear_inputs(); #1;
    checks++;
    if (StallCnt !== 32'd5) begin failures++; $display("FAIL perf_stall got=%0d exp=5", StallCnt); end
    checks++;
    if (FlushCnt !== 32'd3) begin failures++; $display("FAIL perf_flush got=%0d exp=3", FlushCnt); end
  endtask
`endif

  initial begin
    test_reset();
    test_forward();
    test_lwstall();
    test_branch();
    test_mem_wait();
    test_timeout();
`ifdef PERF_CNT_EN
    test_perf();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
